tdm_demux8: RTL and testbench

Eight-channel time-division demultiplexer: recovers frame alignment on a 1-bit serial stream and distributes slot k of each 8-slot frame to parallel output bit k. It sits at the receiving end of an 8:1 bit-serial link, where the transmit side selects one input per slot onto a single wire. Each verified frame is presented as a registered 8-bit word with a one-cycle valid strobe.

---
 rtl/tdm_demux8_if.sv | 34 +++
 rtl/tdm_demux8.sv | 105 ++++++++++
 tb/tb_tdm_demux8.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux8_if.sv
// tdm_demux8_if: slot-strobed serial input and parallel frame output of the demultiplexer.
//   master : link side; drives en/din/frame and observes the recovered outputs
//   slave  : demultiplexer side
//   en          slot strobe
//   din         serial data bit for the current slot
//   frame       slot-0 marker
//   ch          last completed frame, ch[k] = slot k
//   frame_valid one-cycle pulse when ch is updated
//   locked      high while frame alignment is locked
//   sync_err    one-cycle pulse on a framing mismatch
//   slot        index of the next expected slot (0 while hunting)
interface tdm_demux8_if;
  localparam int unsigned NCH    = 8;
  localparam int unsigned SLOT_W = 3;

  logic              en;
  logic              din;
  logic              frame;
  logic [NCH-1:0]    ch;
  logic              frame_valid;
  logic              locked;
  logic              sync_err;
  logic [SLOT_W-1:0] slot;

  modport master (
    output en, din, frame,
    input  ch, frame_valid, locked, sync_err, slot
  );

  modport slave (
    input  en, din, frame,
    output ch, frame_valid, locked, sync_err, slot
  );
endinterface

// File: rtl/tdm_demux8.sv
// tdm_demux8: recovers 8-slot frame alignment on a 1-bit serial stream and presents
// each frame completed while locked as a registered 8-bit word with a valid strobe.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  tdm_demux8_if.slave (en/din/frame in; ch/frame_valid/locked/sync_err/slot out)
//   LOCK_FRAMES  verified boundaries after the initial marker needed to lock (1..15)
module tdm_demux8 #(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux8_if.slave  bus
);
  localparam int unsigned NCH    = 8;
  localparam int unsigned SLOT_W = 3;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state;
  logic [NCH-1:0]      shadow;
  logic [SLOT_W-1:0]   slot_q;
  logic [CNT_W-1:0]    good_cnt;
  logic [CNT_W-1:0]    good_next;
  logic [NCH-1:0]      ch_q;
  logic                frame_valid_q;
  logic                locked_q;
  logic                sync_err_q;

  assign good_next = good_cnt + CNT_W'(1);

  // Framing state machine; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= HUNT;
      shadow        <= '0;
      slot_q        <= '0;
      good_cnt      <= '0;
      ch_q          <= '0;
      frame_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      // Pulses last exactly one cycle, including across en=0 gaps.
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (bus.en) begin
        case (state)
          HUNT: begin
            if (bus.frame) begin
              shadow[0] <= bus.din;
              slot_q    <= SLOT_W'(1);
              good_cnt  <= '0;
              state     <= SYNC;
            end
          end
          default: begin
            if (bus.frame && (slot_q != '0)) begin
              // Early marker: restart alignment on this bit as slot 0.
              sync_err_q <= 1'b1;
              shadow[0]  <= bus.din;
              slot_q     <= SLOT_W'(1);
              good_cnt   <= '0;
              locked_q   <= 1'b0;
              state      <= SYNC;
            end else if (!bus.frame && (slot_q == '0)) begin
              // Missing marker: alignment is lost, go back to hunting.
              sync_err_q <= 1'b1;
              slot_q     <= '0;
              good_cnt   <= '0;
              locked_q   <= 1'b0;
              state      <= HUNT;
            end else begin
              shadow[slot_q] <= bus.din;
              slot_q         <= slot_q + SLOT_W'(1);
              if ((state == SYNC) && (slot_q == '0)) begin
                good_cnt <= good_next;
                if (good_next == LOCK_N) begin
                  state    <= LOCKED;
                  locked_q <= 1'b1;
                end
              end
              // Slot 7 bit bypasses the shadow so the word is out the next cycle.
              if ((state == LOCKED) && (slot_q == SLOT_W'(NCH - 1))) begin
                ch_q          <= {bus.din, shadow[NCH-2:0]};
                frame_valid_q <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.ch          = ch_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.locked      = locked_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.slot        = slot_q;
endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: drives two demultiplexers (LOCK_FRAMES=2 and 1) from one stimulus
// stream; a frame-alignment reference model queues the expected outputs per cycle and
// the expected words, and a monitor pops and compares them as the DUTs respond.
module tb_tdm_demux8;
  typedef struct {
    logic [13:0] s0;
    logic [13:0] s1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic din = 1'b0;
  logic frame = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  exp_t       exp_q[$];
  logic [7:0] fq0[$];
  logic [7:0] fq1[$];

  // Reference model: position within the frame (-1 while hunting), verified boundaries.
  int         m_pos  [2];
  int         m_ver  [2];
  bit         m_lock [2];
  bit   [7:0] m_bits [2];
  bit   [7:0] m_ch   [2];
  int         m_l    [2] = '{2, 1};

  tdm_demux8_if if0 ();
  tdm_demux8_if if1 ();

  assign if0.en = en;
  assign if0.din = din;
  assign if0.frame = frame;
  assign if1.en = en;
  assign if1.din = din;
  assign if1.frame = frame;

  tdm_demux8 #(.LOCK_FRAMES(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  tdm_demux8 #(.LOCK_FRAMES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] snap(input int i);
    if (i == 0) return {if0.ch, if0.frame_valid, if0.locked, if0.sync_err, if0.slot};
    return {if1.ch, if1.frame_valid, if1.locked, if1.sync_err, if1.slot};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = -1;
      m_ver[i] = 0;
      m_lock[i] = 1'b0;
      m_bits[i] = '0;
      m_ch[i] = '0;
    end
    fq0.delete();
    fq1.delete();
  endfunction

  function automatic logic [13:0] model_one(input int i, input bit e, input bit d, input bit f);
    bit fv = 1'b0;
    bit se = 1'b0;
    if (e) begin
      if (m_pos[i] < 0) begin
        if (f) begin
          m_bits[i][0] = d;
          m_pos[i] = 1;
          m_ver[i] = 0;
        end
      end else if (f != (m_pos[i] == 0)) begin
        se = 1'b1;
        m_lock[i] = 1'b0;
        m_ver[i] = 0;
        if (f) begin
          m_bits[i][0] = d;
          m_pos[i] = 1;
        end else begin
          m_pos[i] = -1;
        end
      end else begin
        m_bits[i][m_pos[i]] = d;
        if (m_pos[i] == 0 && !m_lock[i]) begin
          m_ver[i]++;
          if (m_ver[i] == m_l[i]) m_lock[i] = 1'b1;
        end
        if (m_pos[i] == 7 && m_lock[i]) begin
          m_ch[i] = m_bits[i];
          fv = 1'b1;
          if (i == 0) fq0.push_back(m_bits[i]);
          else fq1.push_back(m_bits[i]);
        end
        m_pos[i] = (m_pos[i] + 1) % 8;
      end
    end
    return {m_ch[i], fv, m_lock[i], se, 3'(m_pos[i] < 0 ? 0 : m_pos[i])};
  endfunction

  task automatic step(input bit e, input bit d, input bit f);
    exp_t x;
    @(negedge clk);
    en = e;
    din = d;
    frame = f;
    x.s0 = model_one(0, e, d, f);
    x.s1 = model_one(1, e, d, f);
    exp_q.push_back(x);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic push_reset_snap();
    exp_t x;
    x.s0 = '0;
    x.s1 = '0;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    model_reset();
    push_reset_snap();
    #1;
    chk("rst_async0", 32'(snap(0)), 32'h0);
    chk("rst_async1", 32'(snap(1)), 32'h0);
    @(negedge clk);
    push_reset_snap();
    @(negedge clk);
    rst = 1'b0;
    push_reset_snap();
  endtask

  task automatic send_frame(input logic [7:0] v);
    for (int k = 0; k < 8; k++) step(1'b1, v[k], k == 0);
  endtask

  // Frames A5,3C,96,0F from HUNT, with `gap` idle (en=0) cycles before each slot.
  task automatic run_stream(input int gap);
    logic [7:0] fr [4] = '{8'hA5, 8'h3C, 8'h96, 8'h0F};
    for (int idx = 0; idx < 32; idx++) begin
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'($urandom));
      step(1'b1, fr[idx / 8][idx % 8], (idx % 8) == 0);
      if (idx == 15 || idx == 16 || idx == 23 || idx == 31 || idx == 8) begin
        settle();
        if (idx == 8)  chk("l1_lock_idx8", 32'(if1.locked), 32'd1);
        if (idx == 15) chk("pre_lock_idx15", 32'(if0.locked), 32'd0);
        if (idx == 16) chk("lock_idx16", 32'(if0.locked), 32'd1);
        if (idx == 23) chk("word_idx23", {23'd0, if0.frame_valid, if0.ch}, 32'h196);
        if (idx == 31) chk("word_idx31", {23'd0, if0.frame_valid, if0.ch}, 32'h10F);
      end else if (idx < 23) begin
        settle();
        chk("no_early_fv", 32'(if0.frame_valid), 32'd0);
      end
    end
  endtask

  // Monitor: pops the per-cycle expectation and checks every presented word.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out0", 32'(snap(0)), 32'(e.s0));
      chk("out1", 32'(snap(1)), 32'(e.s1));
    end
    if (if0.frame_valid === 1'b1) begin
      chk("fv0_pending", 32'(fq0.size() > 0), 32'd1);
      if (fq0.size() > 0) chk("word0", 32'(if0.ch), 32'(fq0.pop_front()));
    end
    if (if1.frame_valid === 1'b1) begin
      chk("fv1_pending", 32'(fq1.size() > 0), 32'd1);
      if (fq1.size() > 0) chk("word1", 32'(if1.ch), 32'(fq1.pop_front()));
    end
  end

  initial begin
    int tx_pos;
    bit e;
    bit f;
    model_reset();
    do_reset();

    // Lock and capture, continuous en.
    run_stream(0);

    // Lost marker in LOCKED.
    step(1'b1, 1'b1, 1'b0);
    settle();
    chk("lost_sync_err", 32'(if0.sync_err), 32'd1);
    chk("lost_locked", 32'(if0.locked), 32'd0);
    chk("lost_ch_hold", {23'd0, if0.frame_valid, if0.ch}, 32'h00F);
    for (int k = 0; k < 8; k++) step(1'b1, 1'($urandom), 1'b0);
    settle();
    chk("hunt_slot", 32'(if0.slot), 32'd0);

    // Gapped en: same stream with en every third cycle.
    run_stream(2);

    // Early marker at slot 5 in LOCKED, then relock with L=2.
    for (int k = 0; k < 5; k++) step(1'b1, 1'($urandom), k == 0);
    step(1'b1, 1'b1, 1'b1);
    settle();
    chk("early_sync_err", 32'(if0.sync_err), 32'd1);
    chk("early_locked", 32'(if0.locked), 32'd0);
    chk("early_slot", 32'(if0.slot), 32'd1);
    for (int k = 1; k < 8; k++) step(1'b1, 1'($urandom), 1'b0);
    send_frame(8'h5A);
    settle();
    chk("relock_pending", 32'(if0.locked), 32'd0);
    send_frame(8'hC3);
    settle();
    chk("relock_word", {23'd0, if0.frame_valid, if0.locked, if0.ch}, 32'h3C3);

    // Reset mid-frame while locked at slot 4.
    for (int k = 0; k < 4; k++) step(1'b1, 1'($urandom), k == 0);
    settle();
    chk("pre_rst_slot4", {30'd0, if0.locked, 1'b0} | 32'(if0.slot << 2), 32'h12);
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 1'($urandom), 1'b0);
    settle();
    chk("post_rst_idle", {29'd0, if0.locked, if0.slot == 3'd0, if1.locked}, 32'h2);

    // L=1: stray marker in HUNT, then a correct stream 8 slots later.
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 1'($urandom), 1'b0);
    step(1'b1, 1'($urandom), 1'b1);
    for (int k = 1; k < 8; k++) step(1'b1, 1'($urandom), 1'b0);
    send_frame(8'h11);
    settle();
    chk("l1_word_first", {23'd0, if1.frame_valid, if1.ch}, 32'h111);
    send_frame(8'h22);
    settle();
    chk("l1_word_second", 32'(if1.ch), 32'h22);

    // Randomized stream: mostly well-framed with occasional marker errors and gaps.
    do_reset();
    tx_pos = $urandom_range(0, 7);
    for (int n = 0; n < 600; n++) begin
      e = ($urandom % 10) < 7;
      f = (tx_pos == 0);
      if (($urandom % 40) == 0) f = ~f;
      step(e, 1'($urandom), f);
      if (e) tx_pos = (tx_pos + 1) % 8;
      if (n == 300) do_reset();
    end

    step(1'b0, 1'b0, 1'b0);
    settle();
    settle();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("fq0_drained", 32'(fq0.size()), 32'd0);
    chk("fq1_drained", 32'(fq1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
